// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive/transmit pair.
// Holds the receiver state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_OVERSAMPLE_DEFAULT = 16;
    localparam int UART_DATA_BITS_DEFAULT  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so an idle-high line resets to 1.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double-register the raw input to settle metastability
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver with valid/ready output and sticky flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at each sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_datastream,
    input  logic                 rx_data_ready,
    input  logic                 rx_framing_err_clr,
    input  logic                 rx_overrun_clr,
    output logic                 rx_data_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_overrun,
    output logic                 rx_framing_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] C_LAST = IW'(DATA_BITS - 1);

    uart_rx_state_t       r_state;
    uart_rx_state_t       w_next;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_ferr;

    logic w_rxs;
    logic w_bit;
    logic w_half_pt;
    logic w_full_pt;
    logic w_cnt_run;
    logic w_cnt_clr;
    logic w_shift;
    logic w_deliver;
    logic w_ferr_set;
    logic w_accept;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk(clk),
        .i_rst(rst),
        .i_d  (rx_datastream),
        .o_q  (w_rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    logic r_h1;
    logic r_h2;

    // Keep the two previous synchronized samples for the vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= w_rxs;
            r_h2 <= r_h1;
        end
    end

    assign w_bit = (r_h1 & r_h2) | (r_h1 & w_rxs) | (r_h2 & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    assign w_half_pt = (r_cnt == C_HALF);
    assign w_full_pt = (r_cnt == C_FULL);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decision from the bit timing and sampled line
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!w_rxs) w_next = START;
            end
            START: begin
                if (w_half_pt) w_next = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_full_pt && r_idx == C_LAST) w_next = STOP;
            end
            STOP: begin
                if (w_full_pt) w_next = w_bit ? IDLE : BREAK;
            end
            BREAK: begin
                if (w_rxs) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        w_cnt_run  = 1'b0;
        w_cnt_clr  = 1'b0;
        w_shift    = 1'b0;
        w_deliver  = 1'b0;
        w_ferr_set = 1'b0;
        unique case (r_state)
            START: begin
                w_cnt_run = 1'b1;
                w_cnt_clr = w_half_pt;
            end
            DATA: begin
                w_cnt_run = 1'b1;
                w_cnt_clr = w_full_pt;
                w_shift   = w_full_pt;
            end
            STOP: begin
                w_cnt_run  = 1'b1;
                w_cnt_clr  = w_full_pt;
                w_deliver  = w_full_pt & w_bit;
                w_ferr_set = w_full_pt & ~w_bit;
            end
            default: begin
                w_cnt_run = 1'b0;
            end
        endcase
    end

    assign w_accept = ~r_valid | rx_data_ready;

    // Bit timing counter, bit index and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (!w_cnt_run || w_cnt_clr) r_cnt <= '0;
            else                         r_cnt <= r_cnt + CW'(1);
            if (r_state != DATA) r_idx <= '0;
            else if (w_shift)    r_idx <= r_idx + IW'(1);
            if (w_shift) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
        end
    end

    // Output byte, handshake and sticky flags (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_deliver && w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_data_ready) begin
                r_valid <= 1'b0;
            end
            if (w_deliver && !w_accept) r_overrun <= 1'b1;
            else if (rx_overrun_clr)    r_overrun <= 1'b0;
            if (w_ferr_set)              r_ferr <= 1'b1;
            else if (rx_framing_err_clr) r_ferr <= 1'b0;
        end
    end

    assign rx_data_valid  = r_valid;
    assign rx_data        = r_data;
    assign rx_overrun     = r_overrun;
    assign rx_framing_err = r_ferr;

endmodule
